// File: rtl/watchdog_vote_pkg.sv
// watchdog_vote_pkg: shared FSM encoding and default sizing for the watchdog vote monitor.
package watchdog_vote_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    localparam int DEF_PERSIST_CYCLES = 4;
    localparam int DEF_CNT_W          = 8;

endpackage

// File: rtl/watchdog_vote_monitor_if.sv
// watchdog_vote_monitor_if: watchdog flags and fault-clear in, vote/alarm/fault status out.
interface watchdog_vote_monitor_if
    import watchdog_vote_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic [2:0]       expired_in;
    logic             fault_clr;
    logic             expired_vote;
    logic             alarm;
    logic [2:0]       channel_fault;
    logic [CNT_W-1:0] fault_cnt;

    modport master (
        output expired_in, fault_clr,
        input  expired_vote, alarm, channel_fault, fault_cnt
    );

    modport slave (
        input  expired_in, fault_clr,
        output expired_vote, alarm, channel_fault, fault_cnt
    );

endinterface

// File: rtl/tmr_vote_logic.sv
// tmr_vote_logic: combinational 2-of-3 majority, agreement flag and one-hot minority channel.
module tmr_vote_logic (
    input  logic [2:0] in_i,
    output logic       maj_o,
    output logic       agree_o,
    output logic [2:0] minority_o
);

    // With one dissenter, the minority is the lone bit that differs from the majority.
    always_comb begin
        maj_o      = (in_i[0] & in_i[1]) | (in_i[0] & in_i[2]) | (in_i[1] & in_i[2]);
        agree_o    = (in_i == 3'b000) || (in_i == 3'b111);
        minority_o = maj_o ? ~in_i : in_i;
    end

endmodule

// File: rtl/watchdog_vote_monitor.sv
// watchdog_vote_monitor: registered 2-of-3 vote of the watchdog flags plus persistent-disagreement
// fault detection with sticky channel latch, alarm and saturating fault-event counter.
module watchdog_vote_monitor
    import watchdog_vote_pkg::*;
#(
    parameter int PERSIST_CYCLES = DEF_PERSIST_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    watchdog_vote_monitor_if.slave  bus
);

    localparam int PW = $clog2(PERSIST_CYCLES + 1);

    state_e           state_q;
    logic [2:0]       in_q;
    logic             vote_q;
    logic             alarm_q;
    logic [2:0]       channel_fault_q;
    logic [CNT_W-1:0] fault_cnt_q;
    logic [PW-1:0]    persist_cnt_q;
    logic [2:0]       suspect_ch_q;

    logic             maj;
    logic             agree;
    logic [2:0]       minority;
    logic [PW-1:0]    persist_d;
    logic             fault_entry_d;
    logic [CNT_W-1:0] fault_cnt_d;

    tmr_vote_logic u_vote (
        .in_i       (in_q),
        .maj_o      (maj),
        .agree_o    (agree),
        .minority_o (minority)
    );

    // Fault entry is reachable from OK only when a single disagreeing sample qualifies.
    always_comb begin
        persist_d     = persist_cnt_q + PW'(1);
        fault_entry_d = !agree && (
            (state_q == ST_OK && PERSIST_CYCLES == 1) ||
            (state_q == ST_SUSPECT && minority == suspect_ch_q && persist_d == PW'(PERSIST_CYCLES)));
        fault_cnt_d   = (fault_cnt_q == '1) ? fault_cnt_q : fault_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_OK;
            in_q            <= '0;
            vote_q          <= 1'b0;
            alarm_q         <= 1'b0;
            channel_fault_q <= '0;
            fault_cnt_q     <= '0;
            persist_cnt_q   <= '0;
            suspect_ch_q    <= '0;
        end else begin
            in_q   <= bus.expired_in;
            vote_q <= maj;
            if (fault_entry_d) begin
                state_q         <= ST_FAULT;
                alarm_q         <= 1'b1;
                channel_fault_q <= minority;
                fault_cnt_q     <= fault_cnt_d;
                persist_cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_OK: begin
                        if (!agree) begin
                            state_q       <= ST_SUSPECT;
                            persist_cnt_q <= PW'(1);
                            suspect_ch_q  <= minority;
                        end
                    end
                    ST_SUSPECT: begin
                        if (agree) begin
                            state_q       <= ST_OK;
                            persist_cnt_q <= '0;
                        end else if (minority != suspect_ch_q) begin
                            persist_cnt_q <= PW'(1);
                            suspect_ch_q  <= minority;
                        end else begin
                            persist_cnt_q <= persist_d;
                        end
                    end
                    ST_FAULT: begin
                        if (bus.fault_clr) begin
                            state_q         <= ST_OK;
                            alarm_q         <= 1'b0;
                            channel_fault_q <= '0;
                        end
                    end
                    default: state_q <= ST_OK;
                endcase
            end
        end
    end

    assign bus.expired_vote  = vote_q;
    assign bus.alarm         = alarm_q;
    assign bus.channel_fault = channel_fault_q;
    assign bus.fault_cnt     = fault_cnt_q;

endmodule
